// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART defaults and FIFO operation encoding used by the receiver, its RX buffer
// and the future transmitter, so every block agrees on widths and rates.
package uart_rx_fifo_pkg;

    localparam int unsigned UART_RATE   = 115200;
    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned FIFO_ADDR_W = 4;

    // Per-cycle decision of the FIFO control: push, pop, or drop the incoming byte.
    typedef struct packed {
        logic wr;
        logic rd;
        logic drop;
    } fifo_op_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port RAM, DEPTH x DATA_W, synchronous write and registered synchronous read.
// Only the read register is reset; array contents are left undefined after reset.
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = FIFO_ADDR_W,
    parameter int unsigned DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write on an address collision: the popped byte is the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures each byte_rxed strobe into a circular FIFO and exposes a
// registered read port, fill level and a sticky overflow flag for bytes lost while full.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = FIFO_ADDR_W,
    parameter int unsigned DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_rxed,
    input  logic [DATA_W-1:0] rx_byte,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    fifo_op_t         op;

    // Status is derived from registered pointers only; MSB is the wrap bit.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A read in the same cycle frees a slot, so a write to a full FIFO is then accepted.
    always_comb begin
        op      = '0;
        op.rd   = rd_en && !empty;
        op.wr   = byte_rxed && (!full || op.rd);
        op.drop = byte_rxed && !op.wr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (op.wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (op.rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= op.rd;
        end
    end

    // Sticky: a drop in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (op.drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (op.wr),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (rx_byte),
        .rd_en   (op.rd),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

endmodule
